// File: rtl/mips_pkg.sv
// Shared mips32 pipeline types: branch codes, branch_ctrl states
// and the default register address width.
package mips_pkg;

  localparam int REG_AW_DFLT = 5;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_code_e;

  typedef enum logic [1:0] {
    BC_IDLE   = 2'b00,
    BC_STALL  = 2'b01,
    BC_SQUASH = 2'b10
  } bc_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage branch control bundle: decoder, EX/MEM destinations,
// comparator result in; compare code, PC select, stall/kill out.
interface branch_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [1:0]        id_code;
  logic              id_is_jr;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_rd;
  logic              cmp_isBranch;
  logic [1:0]        cmp_code;
  logic              pc_sel;
  logic              stall;
  logic              id_kill;
  logic              hazard_timeout;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output id_valid, id_code, id_is_jr,
    output id_rs, id_rt,
    output ex_reg_write, ex_mem_read, ex_rd,
    output mem_mem_read, mem_rd,
    output cmp_isBranch,
    input  cmp_code, pc_sel, stall, id_kill,
    input  hazard_timeout, branch_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, id_code, id_is_jr,
    input  id_rs, id_rt,
    input  ex_reg_write, ex_mem_read, ex_rd,
    input  mem_mem_read, mem_rd,
    input  cmp_isBranch,
    output cmp_code, pc_sel, stall, id_kill,
    output hazard_timeout, branch_cnt, taken_cnt
  );

endinterface

// File: rtl/branch_hazard.sv
// Combinational rs/rt source match against EX and MEM destinations.
// Register 0 never hazards; j/jal read no sources.
module branch_hazard
  import mips_pkg::*;
#(
  parameter int REG_AW = REG_AW_DFLT
) (
  input  br_code_e          code_i,
  input  logic              is_jr_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  output logic              hazard_o
);

  logic use_rs;
  logic use_rt;
  logic ex_wr;
  logic rs_hz;
  logic rt_hz;

  function automatic logic src_hz(
    input logic [REG_AW-1:0] s,
    input logic              exw,
    input logic [REG_AW-1:0] exd,
    input logic              mld,
    input logic [REG_AW-1:0] md
  );
    return (s != '0) &&
           ((exw && exd == s) ||
            (mld && md == s));
  endfunction

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    unique case (1'b1)
      (code_i == BR_BEQ),
      (code_i == BR_BNE): begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      (code_i == BR_JMP): use_rs = is_jr_i;
      default: ;
    endcase
  end

  assign ex_wr = ex_reg_write_i | ex_mem_read_i;

  assign rs_hz = use_rs &&
    src_hz(rs_i, ex_wr, ex_rd_i,
           mem_mem_read_i, mem_rd_i);

  assign rt_hz = use_rt &&
    src_hz(rt_i, ex_wr, ex_rd_i,
           mem_mem_read_i, mem_rd_i);

  assign hazard_o = rs_hz | rt_hz;

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: hazard stall, compare, PC redirect, kill.
// MIPS_DELAY_SLOT_EN: taken transfers skip SQUASH, id_kill tied 0.
module branch_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DFLT,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input logic          clock,
  input logic          reset,
  branch_ctrl_if.slave bus
);

  localparam int SCW = $clog2(MAX_STALL + 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(MAX_STALL);

`ifdef MIPS_DELAY_SLOT_EN
  localparam bit SQUASH_EN = 1'b0;
`else
  localparam bit SQUASH_EN = 1'b1;
`endif

  br_code_e         code;
  bc_state_e        state_q;
  bc_state_e        state_d;
  logic [SCW-1:0]   stall_cnt_q;
  logic [SCW-1:0]   stall_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;
  logic             timeout_q;
  logic             hazard;
  logic             br;
  logic             br_inc;
  logic             tk_inc;
  logic             stall_c;
  logic             pc_sel_c;
  br_code_e         cmp_code_c;

  assign code = br_code_e'(bus.id_code);

  branch_hazard #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .code_i         (code),
    .is_jr_i        (bus.id_is_jr),
    .rs_i           (bus.id_rs),
    .rt_i           (bus.id_rt),
    .ex_reg_write_i (bus.ex_reg_write),
    .ex_mem_read_i  (bus.ex_mem_read),
    .ex_rd_i        (bus.ex_rd),
    .mem_mem_read_i (bus.mem_mem_read),
    .mem_rd_i       (bus.mem_rd),
    .hazard_o       (hazard)
  );

  assign br = bus.id_valid &&
              (code != BR_NONE) &&
              (state_q != BC_SQUASH);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_c     = 1'b0;
    pc_sel_c    = 1'b0;
    cmp_code_c  = BR_NONE;
    br_inc      = 1'b0;
    tk_inc      = 1'b0;
    unique case (state_q)
      BC_IDLE, BC_STALL: begin
        if (br && hazard) begin
          stall_c = 1'b1;
          state_d = BC_STALL;
          if (stall_cnt_q != SC_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (br) begin
          cmp_code_c  = code;
          pc_sel_c    = bus.cmp_isBranch;
          br_inc      = 1'b1;
          tk_inc      = bus.cmp_isBranch;
          stall_cnt_d = '0;
          state_d = (bus.cmp_isBranch && SQUASH_EN)
                  ? BC_SQUASH : BC_IDLE;
        end else begin
          stall_cnt_d = '0;
          state_d     = BC_IDLE;
        end
      end
      BC_SQUASH: state_d = BC_IDLE;
      default:   state_d = BC_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even mid-branch.
  assign bus.stall    = reset & stall_c;
  assign bus.pc_sel   = reset & pc_sel_c;
  assign bus.cmp_code = reset ? cmp_code_c : BR_NONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= BC_IDLE;
      stall_cnt_q  <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      if (br_inc)
        branch_cnt_q <= branch_cnt_q + 1'b1;
      if (tk_inc)
        taken_cnt_q <= taken_cnt_q + 1'b1;
      if (stall_cnt_d == SC_MAX)
        timeout_q <= 1'b1;
    end
  end

`ifdef MIPS_DELAY_SLOT_EN
  assign bus.id_kill = 1'b0;
`else
  logic kill_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      kill_q <= 1'b0;
    else
      kill_q <= (state_d == BC_SQUASH);
  end

  assign bus.id_kill = kill_q;
`endif

  assign bus.hazard_timeout = timeout_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed vector table plus hand sequences for branch_ctrl.
module tb_branch_ctrl;
  import mips_pkg::*;

`ifdef MIPS_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk;
  logic rst_n;

  branch_ctrl_if #(.REG_AW(5), .CNT_W(16)) bif ();

  branch_ctrl #(
    .REG_AW    (5),
    .CNT_W     (16),
    .MAX_STALL (3)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [1:0] code;
    bit       jr;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       exw;
    bit       exl;
    bit [4:0] exrd;
    bit       meml;
    bit [4:0] memrd;
    bit       cmp;
    bit       e_stall;
    bit [1:0] e_code;
    bit       e_pc;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_tk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bif.id_valid     = x.v;
    bif.id_code      = x.code;
    bif.id_is_jr     = x.jr;
    bif.id_rs        = x.rs;
    bif.id_rt        = x.rt;
    bif.ex_reg_write = x.exw;
    bif.ex_mem_read  = x.exl;
    bif.ex_rd        = x.exrd;
    bif.mem_mem_read = x.meml;
    bif.mem_rd       = x.memrd;
    bif.cmp_isBranch = x.cmp;
  endtask

  task automatic idle();
    vec_t z;
    z = '{default: '0};
    drive(z);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input string nm, input bit s,
                            input int c, input bit p);
    chk({nm, ".stall"}, int'(bif.stall), int'(s));
    chk({nm, ".cmp_code"}, int'(bif.cmp_code), c);
    chk({nm, ".pc_sel"}, int'(bif.pc_sel), int'(p));
  endtask

  task automatic check_cnt(input string nm);
    chk({nm, ".branch_cnt"}, int'(bif.branch_cnt), exp_br);
    chk({nm, ".taken_cnt"}, int'(bif.taken_cnt), exp_tk);
  endtask

  initial begin
    vec_t x;
    bit res;
    bit tk;

    //            v code jr rs rt exw exl exrd meml memrd cmp | st code pc
    vt[0]  = '{1, 2'b01, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 2'b01, 1};
    vt[1]  = '{1, 2'b01, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0};
    vt[2]  = '{1, 2'b10, 0, 4, 1, 0, 1, 4, 0, 0, 1, 1, 2'b00, 0};
    vt[3]  = '{1, 2'b01, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 2'b01, 1};
    vt[4]  = '{1, 2'b01, 0, 2, 5, 1, 0, 5, 0, 0, 0, 1, 2'b00, 0};
    vt[5]  = '{1, 2'b11, 1, 7, 0, 0, 0, 0, 1, 7, 1, 1, 2'b00, 0};
    vt[6]  = '{1, 2'b11, 0, 7, 7, 1, 0, 7, 1, 7, 1, 0, 2'b11, 1};
    vt[7]  = '{1, 2'b10, 0, 6, 1, 0, 0, 0, 0, 6, 1, 0, 2'b10, 1};
    vt[8]  = '{0, 2'b01, 0, 3, 3, 1, 0, 3, 0, 0, 1, 0, 2'b00, 0};
    vt[9]  = '{1, 2'b00, 0, 3, 3, 1, 0, 3, 0, 0, 1, 0, 2'b00, 0};
    vt[10] = '{1, 2'b01, 0, 9, 9, 1, 0, 9, 1, 9, 1, 1, 2'b00, 0};
    vt[11] = '{1, 2'b11, 0, 9, 9, 1, 0, 9, 1, 9, 1, 0, 2'b11, 1};
    vt[12] = '{1, 2'b01, 0, 1, 8, 0, 1, 8, 0, 0, 0, 1, 2'b00, 0};

    // Reset: outputs quiet even with a live branch on the inputs
    rst_n = 1'b0;
    drive(vt[0]);
    tick();
    tick();
    check_comb("rst", 0, 0, 0);
    chk("rst.id_kill", int'(bif.id_kill), 0);
    chk("rst.timeout", int'(bif.hazard_timeout), 0);
    check_cnt("rst");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      x = vt[i];
      drive(x);
      #1;
      check_comb($sformatf("v%0d", i), x.e_stall, int'(x.e_code), x.e_pc);
      res = x.v && (x.code != 2'b00) && !x.e_stall;
      tk  = res && x.cmp;
      tick();
      if (res) exp_br++;
      if (tk) exp_tk++;
      chk($sformatf("v%0d.id_kill", i), int'(bif.id_kill), int'(tk && !DS));
      idle();
      tick();
      chk($sformatf("v%0d.kill_clr", i), int'(bif.id_kill), 0);
    end
    check_cnt("table");

    // Load in EX then MEM: two stalls, resolve on the third cycle
    x = '{default: '0};
    x.v = 1; x.code = 2'b10; x.rs = 4; x.rt = 1;
    x.exl = 1; x.exrd = 4;
    drive(x);
    #1;
    check_comb("ld.c1", 1, 0, 0);
    tick();
    x.exl = 0; x.exrd = 0; x.meml = 1; x.memrd = 4;
    drive(x);
    #1;
    check_comb("ld.c2", 1, 0, 0);
    tick();
    x.meml = 0; x.memrd = 0;
    drive(x);
    #1;
    check_comb("ld.c3", 0, 2, 0);
    tick();
    exp_br++;
    chk("ld.stall_cnt", int'(dut.stall_cnt_q), 0);
    check_cnt("ld");
    idle();
    tick();

    // Branch during SQUASH is ignored and not counted
    x = '{default: '0};
    x.v = 1; x.code = 2'b01; x.rs = 3; x.rt = 3; x.cmp = 1;
    drive(x);
    #1;
    check_comb("sq.c1", 0, 1, 1);
    tick();
    exp_br++;
    exp_tk++;
    #1;
    check_comb("sq.c2", 0, DS ? 1 : 0, DS);
    chk("sq.id_kill", int'(bif.id_kill), int'(!DS));
    tick();
    if (DS) begin
      exp_br++;
      exp_tk++;
    end
    check_cnt("sq");
    idle();
    tick();

    // Reset asserted mid-stall
    x = '{default: '0};
    x.v = 1; x.code = 2'b01; x.rs = 4; x.rt = 1;
    x.exl = 1; x.exrd = 4;
    drive(x);
    tick();
    chk("rs.stall_pre", int'(bif.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rs.stall", int'(bif.stall), 0);
    chk("rs.state", int'(dut.state_q), int'(BC_IDLE));
    exp_br = 0;
    exp_tk = 0;
    check_cnt("rs");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-squash drops the pending kill
    x = '{default: '0};
    x.v = 1; x.code = 2'b01; x.rs = 3; x.rt = 3; x.cmp = 1;
    drive(x);
    tick();
    idle();
    chk("rq.kill_pre", int'(bif.id_kill), int'(!DS));
    rst_n = 1'b0;
    #1;
    chk("rq.id_kill", int'(bif.id_kill), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rq.kill_post", int'(bif.id_kill), 0);

    // Watchdog: two stalls legal, third flags, then sticky
    x = '{default: '0};
    x.v = 1; x.code = 2'b01; x.rs = 2; x.rt = 1;
    x.exw = 1; x.exrd = 2;
    drive(x);
    tick();
    tick();
    chk("wd.c2", int'(bif.hazard_timeout), 0);
    tick();
    chk("wd.c3", int'(bif.hazard_timeout), 1);
    chk("wd.stall_sat", int'(bif.stall), 1);
    idle();
    tick();
    tick();
    chk("wd.sticky", int'(bif.hazard_timeout), 1);
    chk("wd.stall_off", int'(bif.stall), 0);
    rst_n = 1'b0;
    #1;
    chk("wd.rst", int'(bif.hazard_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
